// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_unit
// Description : Fetches the instruction stream from a variable-latency RAM,
//               one 16-bit word at a time, and holds each word until the
//               control unit consumes it. Supports PC redirect (jump) with
//               discard of an in-flight read, and a sticky RAM timeout fault.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   ADDR_W      width of the fetch PC / RAM address
//   RESET_PC    fetch PC value after reset
//   MAX_WAIT    cycles to wait for mem_rvalid before declaring a fault (>=1)
// Ports
//   clk          in   clock, all state changes on the rising edge
//   rst          in   synchronous active-high reset
//   mem_addr     out  RAM read address (= fetch PC, meaningful while mem_rd=1)
//   mem_rd       out  one-cycle read request strobe
//   mem_rdata    in   RAM read data, sampled only with mem_rvalid
//   mem_rvalid   in   RAM read data valid, one cycle per request
//   instr        out  instruction word held for the control unit
//   instr_pc     out  address the held word was fetched from
//   instr_valid  out  instr holds an unconsumed word (registered)
//   instr_ready  in   consumer accepts instr this cycle
//   pc_load      in   redirect the fetch PC (jump)
//   pc_load_val  in   new fetch PC
//   fetch_err    out  sticky RAM timeout fault (registered)
// ============================================================================
module instr_fetch_unit #(
  parameter int                MAX_WAIT = 15,
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [15:0]       mem_rdata,
  input  logic              mem_rvalid,
  output logic [15:0]       instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_load_val,
  output logic              fetch_err
);

  // Counter wide enough to hold MAX_WAIT itself.
  localparam int              CNT_W      = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(MAX_WAIT);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_HOLD  = 3'd3,
    S_DRAIN = 3'd4,
    S_ERR   = 3'd5
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] fetch_pc_nxt;
  logic [15:0]       instr_nxt;
  logic [ADDR_W-1:0] instr_pc_nxt;
  logic [CNT_W-1:0]  wait_cnt;
  logic [CNT_W-1:0]  wait_cnt_nxt;
  logic [CNT_W-1:0]  wait_cnt_inc;
  logic              timeout;

  // The counter saturates at the limit: a redirect out of WAIT can defer the
  // timeout decision by a cycle, and DRAIN must still see the limit reached.
  assign wait_cnt_inc = (wait_cnt == WAIT_LIMIT) ? wait_cnt : wait_cnt + CNT_W'(1);
  assign timeout      = (wait_cnt_inc == WAIT_LIMIT);

  assign mem_addr = fetch_pc;

  // --------------------------------------------------------------------------
  // Next-state / output logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt    = state;
    fetch_pc_nxt = fetch_pc;
    instr_nxt    = instr;
    instr_pc_nxt = instr_pc;
    wait_cnt_nxt = wait_cnt;
    mem_rd       = 1'b0;

    case (state)
      S_IDLE: begin
        state_nxt = S_REQ;
      end

      // A response arriving here belongs to an orphaned read (issued before a
      // reset) and is ignored by simply not looking at mem_rvalid.
      S_REQ: begin
        mem_rd       = 1'b1;
        wait_cnt_nxt = '0;
        state_nxt    = S_WAIT;
      end

      S_WAIT: begin
        if (mem_rvalid) begin
          instr_nxt    = mem_rdata;
          instr_pc_nxt = fetch_pc;
          fetch_pc_nxt = fetch_pc + ADDR_W'(1);
          state_nxt    = S_HOLD;
        end else begin
          wait_cnt_nxt = wait_cnt_inc;
          if (timeout) begin
            state_nxt = S_ERR;
          end
        end
      end

      S_HOLD: begin
        if (instr_ready) begin
          state_nxt = S_REQ;
        end
      end

      // Waiting out a read whose data is no longer wanted.
      S_DRAIN: begin
        if (mem_rvalid) begin
          state_nxt = S_REQ;
        end else begin
          wait_cnt_nxt = wait_cnt_inc;
          if (timeout) begin
            state_nxt = S_ERR;
          end
        end
      end

      S_ERR: begin
        state_nxt = S_ERR;
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase

    // Redirect overrides every transition above except the fault state. Any
    // word captured in the same cycle is discarded by restoring the holding
    // registers; the wait counter update from above is kept.
    if (pc_load && (state != S_ERR)) begin
      fetch_pc_nxt = pc_load_val;
      instr_nxt    = instr;
      instr_pc_nxt = instr_pc;
      case (state)
        // The read issued this cycle is still outstanding.
        S_REQ:   state_nxt = S_DRAIN;
        // Outstanding unless its data arrives right now.
        S_WAIT:  state_nxt = mem_rvalid ? S_REQ : S_DRAIN;
        S_DRAIN: state_nxt = S_DRAIN;
        default: state_nxt = S_REQ;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      fetch_pc    <= RESET_PC;
      instr       <= '0;
      instr_pc    <= RESET_PC;
      wait_cnt    <= '0;
      instr_valid <= 1'b0;
      fetch_err   <= 1'b0;
    end else begin
      state       <= state_nxt;
      fetch_pc    <= fetch_pc_nxt;
      instr       <= instr_nxt;
      instr_pc    <= instr_pc_nxt;
      wait_cnt    <= wait_cnt_nxt;
      // Registered flags track the state being entered.
      instr_valid <= (state_nxt == S_HOLD);
      fetch_err   <= (state_nxt == S_ERR);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch_unit
// Description : Self-checking bench for instr_fetch_unit. A RAM model answers
//               reads with a configurable latency; a scoreboard queue holds
//               the address of the next word the consumer should see, and a
//               negedge monitor pops and compares every newly presented word.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic [15:0] mem_rdata;
  logic        mem_rvalid;
  logic [15:0] instr;
  logic [15:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        pc_load;
  logic [15:0] pc_load_val;
  logic        fetch_err;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  instr_fetch_unit #(
    .MAX_WAIT (15),
    .ADDR_W   (16),
    .RESET_PC (16'h0000)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .mem_addr    (mem_addr),
    .mem_rd      (mem_rd),
    .mem_rdata   (mem_rdata),
    .mem_rvalid  (mem_rvalid),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .pc_load     (pc_load),
    .pc_load_val (pc_load_val),
    .fetch_err   (fetch_err)
  );

  // RAM contents: the two words of the basic fetch test, otherwise a
  // byte-swapped address pattern so every address returns distinct data.
  function automatic logic [15:0] word_at(input logic [15:0] a);
    if (a == 16'h0000) return 16'h1234;
    if (a == 16'h0001) return 16'h5678;
    return {a[7:0], a[15:8]} ^ 16'hC3A5;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // --------------------------------------------------------------------------
  // RAM model: drives at posedge+1. A read seen in cycle N answers in cycle
  // N+lat. Garbage is driven on mem_rdata whenever mem_rvalid is low.
  // --------------------------------------------------------------------------
  bit          ram_en      = 1'b1;
  int          ram_lat_min = 1;
  int          ram_lat_max = 1;
  int          ram_cnt     = 0;
  logic [15:0] ram_addr    = 16'h0;

  initial begin
    mem_rvalid = 1'b0;
    mem_rdata  = 16'h0;
    forever begin
      @(posedge clk);
      #1;
      mem_rvalid = 1'b0;
      mem_rdata  = 16'($urandom);
      if (rst) begin
        ram_cnt = 0;
      end else begin
        if (ram_cnt > 0) begin
          ram_cnt--;
          if (ram_cnt == 0) begin
            mem_rvalid = 1'b1;
            mem_rdata  = word_at(ram_addr);
          end
        end
        if (mem_rd && ram_en) begin
          ram_addr = mem_addr;
          ram_cnt  = int'($urandom_range(ram_lat_max, ram_lat_min));
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Scoreboard: front entry is the address of the next word to be presented.
  // A presented word pops it and pushes its successor; a redirect replaces the
  // whole expectation with the load value.
  // --------------------------------------------------------------------------
  logic [15:0] sb[$];
  logic [15:0] mon_exp;
  logic        prev_valid = 1'b0;
  logic        prev_take  = 1'b0;
  logic [15:0] prev_instr = 16'h0;
  logic [15:0] prev_pc    = 16'h0;
  int          words_seen = 0;

  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
      prev_take  = 1'b0;
    end else begin
      check("rd_while_valid", 32'(mem_rd & instr_valid), 32'd0);
      if (instr_valid && !prev_valid) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL sb_underflow: word at pc %0h presented, none expected", instr_pc);
        end else begin
          mon_exp = sb.pop_front();
          check("sb_pc", 32'(instr_pc), 32'(mon_exp));
          check("sb_data", 32'(instr), 32'(word_at(mon_exp)));
          sb.push_back(mon_exp + 16'd1);
          words_seen++;
        end
      end else if (instr_valid) begin
        check("no_dup_after_take", 32'(prev_take), 32'd0);
        check("hold_stable", {instr_pc, instr}, {prev_pc, prev_instr});
      end
      prev_valid = instr_valid;
      prev_take  = instr_valid & (instr_ready | pc_load);
      prev_instr = instr;
      prev_pc    = instr_pc;
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers. Inputs change at posedge+2 (after the RAM model), so
  // the current cycle's DUT outputs and mem_rvalid are visible to callers.
  // --------------------------------------------------------------------------
  task automatic do_cycle(input bit rdy, input bit ld, input logic [15:0] val, input bit avoid_rv);
    @(posedge clk);
    #2;
    // The redirect driven last cycle has just been applied by the DUT.
    if (pc_load) begin
      sb.delete();
      sb.push_back(pc_load_val);
    end
    instr_ready = rdy;
    pc_load     = ld & ~(avoid_rv & mem_rvalid);
    pc_load_val = val;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst         = 1'b1;
    instr_ready = 1'b0;
    pc_load     = 1'b0;
    pc_load_val = 16'h0;
    repeat (3) @(posedge clk);
    #2;
    check("rst_flags", 32'({mem_rd, instr_valid, fetch_err}), 32'd0);
    check("rst_instr", 32'(instr), 32'd0);
    check("rst_instr_pc", 32'(instr_pc), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    sb.delete();
    sb.push_back(16'h0000);
    rst = 1'b0;
  endtask

  task automatic run_until_valid(input string name);
    int n = 0;
    while (!instr_valid && n < 40) begin
      do_cycle(1'b0, 1'b0, 16'h0, 1'b0);
      n++;
    end
    check(name, 32'(instr_valid), 32'd1);
  endtask

  task automatic run_until_rd(input string name, output int n);
    n = 0;
    while (!mem_rd && n < 40) begin
      do_cycle(1'b0, 1'b0, 16'h0, 1'b0);
      n++;
    end
    check(name, 32'(mem_rd), 32'd1);
  endtask

  // --------------------------------------------------------------------------
  // Main sequence
  // --------------------------------------------------------------------------
  initial begin
    int          n;
    int          pct;
    logic [15:0] held;
    logic [15:0] v;
    bit          exp_rd;
    bit          exp_v;

    rst         = 1'b1;
    instr_ready = 1'b0;
    pc_load     = 1'b0;
    pc_load_val = 16'h0;

    // Basic fetch: reset lands in cycle 1 (IDLE). With a RAM answering in the
    // cycle after the request, a word takes REQ, WAIT, HOLD: 3 cycles each.
    ram_lat_min = 1;
    ram_lat_max = 1;
    do_reset();
    for (int k = 2; k <= 8; k++) begin
      do_cycle(1'b1, 1'b0, 16'h0, 1'b0);
      exp_rd = (k == 2) || (k == 5) || (k == 8);
      exp_v  = (k == 4) || (k == 7);
      check($sformatf("t1_timing_c%0d", k), 32'({mem_rd, instr_valid}), 32'({exp_rd, exp_v}));
      if (k == 2) check("t1_first_addr", 32'(mem_addr), 32'h0000);
      if (k == 4) check("t1_word0", {instr_pc, instr}, {16'h0000, 16'h1234});
      if (k == 7) check("t1_word1", {instr_pc, instr}, {16'h0001, 16'h5678});
    end

    // Consumer stalls: the word must be held and no new read issued.
    run_until_valid("t2_reach_hold");
    held = instr;
    for (int k = 0; k < 10; k++) begin
      do_cycle(1'b0, 1'b0, 16'h0, 1'b0);
      check("t2_stall", {13'h0, instr_valid, mem_rd, 1'b0, instr}, {13'h0, 1'b1, 1'b0, 1'b0, held});
    end

    // Redirect during WAIT, stale response three cycles after the request.
    ram_lat_min = 3;
    ram_lat_max = 3;
    do_cycle(1'b1, 1'b0, 16'h0, 1'b0);
    run_until_rd("t3_req", n);
    do_cycle(1'b0, 1'b1, 16'h0040, 1'b0);
    run_until_rd("t3_req_after_load", n);
    check("t3_drain_len", 32'(n), 32'd3);
    check("t3_new_addr", 32'(mem_addr), 32'h0040);
    run_until_valid("t3_valid");
    check("t3_word", {instr_pc, instr}, {16'h0040, word_at(16'h0040)});

    // Wrap: fetch from 16'hFFFF, next read at address 0.
    ram_lat_min = 1;
    ram_lat_max = 1;
    do_cycle(1'b1, 1'b0, 16'h0, 1'b0);
    do_cycle(1'b0, 1'b1, 16'hFFFF, 1'b0);
    run_until_valid("t4_valid");
    check("t4_word", {instr_pc, instr}, {16'hFFFF, word_at(16'hFFFF)});
    do_cycle(1'b1, 1'b0, 16'h0, 1'b0);
    run_until_rd("t4_req", n);
    check("t4_wrap_addr", 32'(mem_addr), 32'h0000);

    // Redirect together with consume in HOLD.
    run_until_valid("t6_reach_hold");
    do_cycle(1'b1, 1'b1, 16'h0100, 1'b0);
    do_cycle(1'b0, 1'b0, 16'h0, 1'b0);
    check("t6_next", {15'h0, mem_rd, instr_valid, mem_addr}, {15'h0, 1'b1, 1'b0, 16'h0100});
    run_until_valid("t6_valid");
    check("t6_word_pc", 32'(instr_pc), 32'h0100);

    // Redirect in WAIT in the same cycle as the response: data dropped,
    // straight back to REQ at the new address.
    ram_lat_min = 2;
    ram_lat_max = 2;
    do_cycle(1'b1, 1'b0, 16'h0, 1'b0);
    run_until_rd("t7_req", n);
    do_cycle(1'b0, 1'b0, 16'h0, 1'b0);
    do_cycle(1'b0, 1'b1, 16'h0200, 1'b0);
    do_cycle(1'b0, 1'b0, 16'h0, 1'b0);
    check("t7_next", {15'h0, mem_rd, instr_valid, mem_addr}, {15'h0, 1'b1, 1'b0, 16'h0200});
    run_until_valid("t7_valid");
    check("t7_word_pc", 32'(instr_pc), 32'h0200);

    // Random traffic: variable RAM latency, random consumer, random jumps
    // (never in a cycle carrying a RAM response).
    ram_lat_min = 1;
    ram_lat_max = 4;
    for (int i = 0; i < 800; i++) begin
      pct = int'($urandom_range(99, 0));
      case ($urandom_range(3, 0))
        0:       v = 16'hFFFE;
        1:       v = 16'hFFFF;
        default: v = 16'($urandom);
      endcase
      do_cycle(($urandom_range(9, 0) < 7), (pct < 6), v, 1'b1);
    end
    do_cycle(1'b0, 1'b0, 16'h0, 1'b0);
    check("random_words_seen", 32'(words_seen >= 40), 32'd1);

    // RAM never answers: fault after 15 WAIT cycles, sticky, jumps ignored.
    ram_en = 1'b0;
    do_reset();
    run_until_rd("t5_req", n);
    n = 0;
    while (!fetch_err && n < 40) begin
      do_cycle(1'b0, 1'b0, 16'h0, 1'b0);
      if (!fetch_err) n++;
    end
    check("t5_wait_cycles", 32'(n), 32'd15);
    check("t5_err", 32'(fetch_err), 32'd1);
    for (int k = 0; k < 5; k++) begin
      do_cycle(1'b1, 1'b1, 16'h0300, 1'b0);
      check("t5_sticky", 32'({fetch_err, mem_rd, instr_valid}), 32'b100);
    end
    ram_en = 1'b1;
    do_reset();
    run_until_rd("t5_restart", n);
    check("t5_restart_addr", 32'(mem_addr), 32'h0000);
    run_until_valid("t5_restart_valid");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    fails++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
